// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: 8N1 frames, status word, sticky overrun.
// Define UART_TX_FIFO_EN for a 4-entry FIFO; otherwise a 1-byte holding register.
module uart_tx_port #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [3:0]  BASE_NIBBLE  = 4'h3
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  output logic        sel,
  output logic [15:0] rd_data,
  output logic        txd
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        txd_q, txd_d;
  logic        ovr_q;

  logic        wr_data, wr_clr, bit_end, avail;
  logic        launch, bypass, pop, push, ovr_set;
  logic        q_empty, q_full, busy;
  logic [7:0]  q_head;
  logic        unused;

  assign sel     = ADDR[15:12] == BASE_NIBBLE;
  assign wr_data = W & sel & ~ADDR[0];
  assign wr_clr  = W & sel & ADDR[0] & DOUT[0];
  assign bit_end = cnt_q == LAST;
  assign avail   = ~q_empty | wr_data;
  assign unused  = ^{ADDR[11:1], DOUT[15:8]};

  // An empty queue lets a write go straight to the shifter.
  assign bypass  = launch & q_empty;
  assign pop     = launch & ~q_empty;
  assign push    = wr_data & ~bypass & (~q_full | pop);
  assign ovr_set = wr_data & q_full & ~pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        launch = avail;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (avail) launch = 1'b1;
          else state_d = IDLE;
        end
      end
    endcase
    if (launch) begin
      state_d = START;
      cnt_d   = '0;
      sh_d    = q_empty ? DOUT[7:0] : q_head;
    end
    if (state_d == START)     txd_d = 1'b0;
    else if (state_d == DATA) txd_d = sh_d[0];
    else                      txd_d = 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      if (wr_clr)       ovr_q <= 1'b0;
      else if (ovr_set) ovr_q <= 1'b1;
    end
  end

`ifdef UART_TX_FIFO_EN
  logic [7:0] mem [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_fq;

  assign q_empty = cnt_fq == 3'd0;
  assign q_full  = cnt_fq == 3'd4;
  assign q_head  = mem[rp_q];

  always_ff @(posedge Clock) begin
    if (push) mem[wp_q] <= DOUT[7:0];
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_fq <= '0;
    end else begin
      if (push) wp_q <= wp_q + 2'd1;
      if (pop)  rp_q <= rp_q + 2'd1;
      unique case ({push, pop})
        2'b10:   cnt_fq <= cnt_fq + 3'd1;
        2'b01:   cnt_fq <= cnt_fq - 3'd1;
        default: cnt_fq <= cnt_fq;
      endcase
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_v;

  assign q_empty = ~hold_v;
  assign q_full  = hold_v;
  assign q_head  = hold_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      hold_q <= '0;
      hold_v <= 1'b0;
    end else if (push) begin
      hold_q <= DOUT[7:0];
      hold_v <= 1'b1;
    end else if (pop) begin
      hold_v <= 1'b0;
    end
  end
`endif

  assign busy    = (state_q != IDLE) | ~q_empty;
  assign rd_data = {13'b0, ovr_q, q_full, busy};
  assign txd     = txd_q;

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, Clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have parameter BASE_NIBBLE, default 4'h3, value of ADDR[15:12] that selects this port.
REQ-003 The block SHALL have port Clock  input  1  the system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Resetn  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port ADDR  input  16  processor address register output.
REQ-006 The block SHALL have port DOUT  input  16  processor data-out register output.
REQ-007 The block SHALL have port W  input  1  processor registered write strobe.
REQ-008 The block SHALL have port sel  output  1  combinational; high when ADDR[15:12]==BASE_NIBBLE, for the external din read mux.
REQ-009 The block SHALL have port rd_data  output  16  combinational status word {13'b0, overrun, full, busy}.
REQ-010 The block SHALL have port txd  output  1  registered serial line, idle high.

Function
REQ-011 The block SHALL treat a rising edge with W=1, sel=1 and ADDR[0]=0 as a data write of DOUT[7:0] into the transmit queue.
REQ-012 The block SHALL treat a rising edge with W=1, sel=1, ADDR[0]=1 and DOUT[0]=1 as a clear of the overrun flag; other ADDR[0]=1 writes are ignored.
REQ-013 The block SHALL drop a data write when the queue is full and no pop occurs on the same edge, and SHALL then set overrun (sticky).
REQ-014 The block SHALL accept a data write on a full queue when a pop occurs on the same edge.
REQ-015 The block SHALL run FSM IDLE -> START -> DATA -> STOP -> (START if queue non-empty, else IDLE).
REQ-016 The block SHALL pop the queue head on the edge leaving IDLE or STOP towards START, latching it into an 8-bit shift register.
REQ-017 The block SHALL drive txd=0 in START, shift-register LSB first in DATA (8 bits), and txd=1 in STOP and IDLE.
REQ-018 The block SHALL hold each START, DATA and STOP bit for exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
REQ-019 The block SHALL begin the start bit (txd=0) on the first cycle after the edge that wrote the queue while IDLE.
REQ-020 The block SHALL send back-to-back frames with no idle cycles between STOP and the next START.
REQ-021 The block SHALL assert busy whenever the FSM is not IDLE or the queue is non-empty.
REQ-022 The block SHALL assert full when queue occupancy equals its depth.
REQ-023 The block SHALL ignore reads; rd_data has no side effects.

Reset
REQ-024 The block SHALL, on Resetn low, immediately force txd=1, FSM=IDLE, the queue empty, overrun=0, and the bit and baud counters to 0, so busy=0 and full=0.
REQ-025 The block SHALL abandon a frame in progress when reset is asserted, without completing it.
REQ-026 The block SHALL keep sel and rd_data purely combinational and independent of reset except through their status bits.

Configuration
REQ-027 The block SHALL, with macro UART_TX_FIFO_EN defined, implement the queue as a 4-entry circular FIFO with 2-bit read and write pointers that wrap from 3 to 0.
REQ-028 The block SHALL, without UART_TX_FIFO_EN, implement the queue as a single 8-bit holding register (depth 1), with all other requirements unchanged.

Verification (bench uses CLKS_PER_BIT=4, FIFO enabled unless noted)
REQ-029 The bench SHALL check: write 0x3000 DOUT=0x00A5 -> txd: 4 cycles of 0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles of 1; busy falls after 40 cycles.
REQ-030 The bench SHALL check: 5 back-to-back writes 0x11..0x15 while IDLE -> all 5 accepted (1 popped at once, 4 queued), full=1 after the 5th, overrun=0, five contiguous frames.
REQ-031 The bench SHALL check: 6 writes while the first frame is active -> the 6th is dropped, overrun=1; write 0x3001 DOUT=0x0001 -> overrun=0.
REQ-032 The bench SHALL check: queue full, write on the STOP->START pop edge -> the write is accepted, full stays 1, overrun=0.
REQ-033 The bench SHALL check: Resetn low mid-DATA -> txd=1 asynchronously, rd_data=0x0000; after release, write 0x3000 0x0F -> a correct frame.
REQ-034 The bench SHALL check, with UART_TX_FIFO_EN undefined: two writes while IDLE -> both accepted; a third during the first frame -> dropped, overrun=1.
